// File: rtl/flot_pkg.sv
// Shared definitions for the flot inverse-square-root front end and merge stage:
// class codes, default operand geometry and the operand classifier.
package flot_pkg;

    localparam int FLOT_WIDTH     = 32;
    localparam int FLOT_WIDTH_EXP = 8;
    localparam int FLOT_WIDTH_MAT = 23;
    localparam int FLOT_SIGN_BIT  = FLOT_WIDTH - 1;
    localparam int FLOT_EXP_HI    = FLOT_WIDTH - 2;
    localparam int FLOT_EXP_LO    = FLOT_WIDTH_MAT;
    localparam int FLOT_CLS_W     = 3;

    typedef logic [FLOT_CLS_W-1:0] flot_cls_t;

    localparam flot_cls_t CLS_NORMAL = 3'd0;
    localparam flot_cls_t CLS_ZERO   = 3'd1;
    localparam flot_cls_t CLS_NEG    = 3'd2;
    localparam flot_cls_t CLS_INF    = 3'd3;
    localparam flot_cls_t CLS_NAN    = 3'd4;
    localparam flot_cls_t CLS_DENORM = 3'd5;

    // Takes field summaries rather than the raw word so one function serves any geometry.
    function automatic flot_cls_t flot_classify(
        input logic sign_s,
        input logic exp_ones_s,
        input logic exp_zero_s,
        input logic mant_zero_s
    );
        flot_cls_t cls_s;
        if (exp_ones_s && !mant_zero_s) begin
            cls_s = CLS_NAN;
        end else if (exp_ones_s && !sign_s) begin
            cls_s = CLS_INF;
        end else if (exp_zero_s && mant_zero_s) begin
            cls_s = CLS_ZERO;
        end else if (sign_s) begin
            cls_s = CLS_NEG;
        end else if (exp_zero_s) begin
            cls_s = CLS_DENORM;
        end else begin
            cls_s = CLS_NORMAL;
        end
        return cls_s;
    endfunction

endpackage

// File: rtl/flot_skid2.sv
// Two-entry skid FIFO. Entry 0 is always the head, so the head output needs no read mux.
module flot_skid2
    import flot_pkg::*;
#(
    parameter int DW = FLOT_WIDTH + FLOT_CLS_W
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] head,
    output logic [1:0]    count
);

    logic [DW-1:0] ent0_r;
    logic [DW-1:0] ent1_r;
    logic [1:0]    cnt_r;

    // Storage and occupancy update; a pop shifts entry 1 down into the head slot.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            ent0_r <= '0;
            ent1_r <= '0;
            cnt_r  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    case (cnt_r)
                        2'd0: begin
                            ent0_r <= din;
                            cnt_r  <= 2'd1;
                        end
                        2'd1: begin
                            ent1_r <= din;
                            cnt_r  <= 2'd2;
                        end
                        default: begin
                            cnt_r <= cnt_r;
                        end
                    endcase
                end
                2'b01: begin
                    if (cnt_r != 2'd0) begin
                        ent0_r <= ent1_r;
                        cnt_r  <= cnt_r - 2'd1;
                    end else begin
                        cnt_r <= 2'd0;
                    end
                end
                2'b11: begin
                    case (cnt_r)
                        2'd2: begin
                            ent0_r <= ent1_r;
                            ent1_r <= din;
                        end
                        default: begin
                            ent0_r <= din;
                            cnt_r  <= 2'd1;
                        end
                    endcase
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign head  = ent0_r;
    assign count = cnt_r;

endmodule

// File: rtl/flot_isqrt_prep.sv
// Operand preparation for the inverse-square-root pipeline: classify, buffer, feed the
// pipeline register and carry {valid, class} down a delay line matched to the pipeline.
module flot_isqrt_prep
    import flot_pkg::*;
#(
    parameter int WIDTH     = FLOT_WIDTH,
    parameter int WIDTH_exp = FLOT_WIDTH_EXP,
    parameter int WIDTH_mat = FLOT_WIDTH_MAT,
    parameter int LAT       = 4
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             hold,
    output logic [WIDTH-1:0] OP,
    output logic             CE,
    output logic             exce,
    output logic             vld_d,
    output logic [2:0]       cls_d
);

    localparam int SK_W = WIDTH + FLOT_CLS_W;

    logic [WIDTH_exp-1:0] exp_s;
    logic [WIDTH_mat-1:0] mant_s;
    flot_cls_t            cls_in_s;
    logic [1:0]           count_s;
    logic [SK_W-1:0]      head_s;
    logic                 advance_s;
    logic                 accept_s;
    logic                 pop_s;
    logic                 push_s;
    logic                 bypass_s;
    logic [WIDTH-1:0]     op_nxt_s;
    flot_cls_t            cls_nxt_s;
    logic                 v_nxt_s;
    logic                 v0_r;
    flot_cls_t            cls0_r;

    assign exp_s    = in_data[WIDTH-2 -: WIDTH_exp];
    assign mant_s   = in_data[WIDTH_mat-1:0];
    assign cls_in_s = flot_classify(in_data[WIDTH-1], &exp_s, ~|exp_s, ~|mant_s);

    assign in_ready  = nRST & (count_s != 2'd2);
    assign CE        = nRST & ~hold;
    assign advance_s = CE;
    assign accept_s  = in_valid & in_ready;
    assign pop_s     = advance_s & (count_s != 2'd0);
    assign bypass_s  = advance_s & (count_s == 2'd0) & accept_s;
    // A beat that goes straight to OP must not also land in the FIFO.
    assign push_s    = accept_s & ~bypass_s;

    flot_skid2 #(
        .DW(SK_W)
    ) u_skid (
        .CLK  (CLK),
        .nRST (nRST),
        .push (push_s),
        .pop  (pop_s),
        .din  ({in_data, cls_in_s}),
        .head (head_s),
        .count(count_s)
    );

    // Source select for the output register: buffered head first, then bypass, else bubble.
    always_comb begin
        op_nxt_s  = '0;
        cls_nxt_s = CLS_NORMAL;
        v_nxt_s   = 1'b0;
        if (count_s != 2'd0) begin
            op_nxt_s  = head_s[SK_W-1:FLOT_CLS_W];
            cls_nxt_s = head_s[FLOT_CLS_W-1:0];
            v_nxt_s   = 1'b1;
        end else if (accept_s) begin
            op_nxt_s  = in_data;
            cls_nxt_s = cls_in_s;
            v_nxt_s   = 1'b1;
        end else begin
            op_nxt_s  = '0;
            cls_nxt_s = CLS_NORMAL;
            v_nxt_s   = 1'b0;
        end
    end

    // Pipeline operand register; frozen while the downstream is stalled.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            OP     <= '0;
            exce   <= 1'b0;
            v0_r   <= 1'b0;
            cls0_r <= CLS_NORMAL;
        end else if (advance_s) begin
            OP     <= op_nxt_s;
            exce   <= (cls_nxt_s != CLS_NORMAL);
            v0_r   <= v_nxt_s;
            cls0_r <= cls_nxt_s;
        end
    end

    generate
        if (LAT == 1) begin : g_direct
            assign vld_d = v0_r;
            assign cls_d = cls0_r;
        end else begin : g_taps
            logic      vld_tap_r [LAT-1];
            flot_cls_t cls_tap_r [LAT-1];

            // Sideband delay line, advancing in lockstep with the pipeline enable.
            always_ff @(posedge CLK) begin
                if (!nRST) begin
                    for (int i = 0; i < LAT - 1; i++) begin
                        vld_tap_r[i] <= 1'b0;
                        cls_tap_r[i] <= CLS_NORMAL;
                    end
                end else if (advance_s) begin
                    vld_tap_r[0] <= v0_r;
                    cls_tap_r[0] <= cls0_r;
                    for (int i = 1; i < LAT - 1; i++) begin
                        vld_tap_r[i] <= vld_tap_r[i-1];
                        cls_tap_r[i] <= cls_tap_r[i-1];
                    end
                end
            end

            assign vld_d = vld_tap_r[LAT-2];
            assign cls_d = cls_tap_r[LAT-2];
        end
    endgenerate

endmodule
